// File: rtl/reg_scoreboard.sv
// reg_scoreboard
//   Tracks in-flight register writes between decode issue and writeback
//   retire, and raises the decode stall / execute-bubble request when an
//   instruction reads a pending register or would overflow the pending
//   counter of its destination.
//
// Ports
//   clk            clock, rising edge
//   rst            asynchronous reset, active low
//   issue_valid    decode holds a valid instruction
//   issue_regwrite decode instruction writes a register
//   issue_rd       decode destination register
//   rs1_d, rs2_d   decode source registers
//   use_rs1/2      decode instruction reads rs1_d / rs2_d
//   retire_valid   writeback writes the register file
//   retire_rd      writeback destination
//   kill_valid     squashed execute-stage instruction that had RegWrite
//   kill_rd        destination of the squashed instruction
//   stall_d        combinational stall / bubble request
//   pending_vec    registered, bit i set while register i has writes in flight
//   stall_count    registered saturating count of stalled cycles
//   err_underflow  registered sticky flag, retire/kill on an idle register
module reg_scoreboard #(
  parameter int NREG = 32,
  parameter int AW   = 5,
  parameter int CW   = 2,
  parameter int SCW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            issue_valid,
  input  logic            issue_regwrite,
  input  logic [AW-1:0]   issue_rd,
  input  logic [AW-1:0]   rs1_d,
  input  logic [AW-1:0]   rs2_d,
  input  logic            use_rs1,
  input  logic            use_rs2,
  input  logic            retire_valid,
  input  logic [AW-1:0]   retire_rd,
  input  logic            kill_valid,
  input  logic [AW-1:0]   kill_rd,
  output logic            stall_d,
  output logic [NREG-1:0] pending_vec,
  output logic [SCW-1:0]  stall_count,
  output logic            err_underflow
);

  localparam logic [CW-1:0] CNT_MAX = '1;

  logic [CW-1:0]   cnt     [NREG];
  logic [CW-1:0]   cnt_nxt [NREG];
  logic [NREG-1:0] pend_nxt;
  logic [NREG-1:0] under;
  logic            rs1_hit;
  logic            rs2_hit;
  logic            rd_full;
  logic            inc;

  // Stall decision from the current counts only; a retire in the same
  // cycle does not release it because the register file has no bypass.
  always_comb begin
    rs1_hit = issue_valid && use_rs1 && (rs1_d != '0) && (cnt[rs1_d] != '0);
    rs2_hit = issue_valid && use_rs2 && (rs2_d != '0) && (cnt[rs2_d] != '0);
    rd_full = issue_valid && issue_regwrite && (issue_rd != '0) &&
              (cnt[issue_rd] == CNT_MAX);
    stall_d = rs1_hit || rs2_hit || rd_full;
    inc     = issue_valid && issue_regwrite && (issue_rd != '0) && !stall_d;
  end

  // Net per-register delta (-2..+1) applied in one step; the arithmetic is
  // widened by two bits so an excess of decrements is detected and clamped.
  always_comb begin
    logic [CW+1:0] sum;
    logic [CW+1:0] dec;
    sum         = '0;
    dec         = '0;
    under       = '0;
    pend_nxt    = '0;
    cnt_nxt[0]  = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      sum = (CW+2)'(cnt[r]) + (CW+2)'(inc && (issue_rd == AW'(r)));
      dec = (CW+2)'(retire_valid && (retire_rd == AW'(r))) +
            (CW+2)'(kill_valid && (kill_rd == AW'(r)));
      if (dec > sum) begin
        under[r]   = 1'b1;
        cnt_nxt[r] = '0;
      end else begin
        cnt_nxt[r] = CW'(sum - dec);
      end
      pend_nxt[r] = (cnt_nxt[r] != '0);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= '0;
      end
      pending_vec   <= '0;
      stall_count   <= '0;
      err_underflow <= 1'b0;
    end else begin
      for (int unsigned r = 0; r < NREG; r++) begin
        cnt[r] <= cnt_nxt[r];
      end
      pending_vec <= pend_nxt;
      if (stall_d && (stall_count != '1)) begin
        stall_count <= stall_count + SCW'(1);
      end
      if (|under) begin
        err_underflow <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_reg_scoreboard.sv
module tb_reg_scoreboard;

  logic        clk;
  logic        rst;
  logic        issue_valid;
  logic        issue_regwrite;
  logic [4:0]  issue_rd;
  logic [4:0]  rs1_d;
  logic [4:0]  rs2_d;
  logic        use_rs1;
  logic        use_rs2;
  logic        retire_valid;
  logic [4:0]  retire_rd;
  logic        kill_valid;
  logic [4:0]  kill_rd;
  logic        stall_d;
  logic [31:0] pending_vec;
  logic [15:0] stall_count;
  logic        err_underflow;

  reg_scoreboard #(.NREG(32), .AW(5), .CW(2), .SCW(16)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_regwrite(issue_regwrite), .issue_rd(issue_rd),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .retire_valid(retire_valid), .retire_rd(retire_rd),
    .kill_valid(kill_valid), .kill_rd(kill_rd),
    .stall_d(stall_d), .pending_vec(pending_vec),
    .stall_count(stall_count), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        iv, rw;
    logic [4:0]  rd, rs1, rs2;
    logic        u1, u2, rv;
    logic [4:0]  rrd;
    logic        kv;
    logic [4:0]  krd;
    logic        es;
    logic [31:0] ep;
    logic        ee;
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: plain integer pending counts per register.
  int m_cnt [32];
  bit m_err;
  int m_stalls;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input bit iv, input bit rw, input int rd, input int rs1,
                              input int rs2, input bit u1, input bit u2, input bit rv,
                              input int rrd, input bit kv, input int krd, input bit es,
                              input logic [31:0] ep, input bit ee);
    vec_t v;
    v.iv = iv; v.rw = rw; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
    v.u1 = u1; v.u2 = u2; v.rv = rv; v.rrd = 5'(rrd); v.kv = kv; v.krd = 5'(krd);
    v.es = es; v.ep = ep; v.ee = ee;
    return v;
  endfunction

  function automatic bit model_stall();
    bit s = 0;
    if (issue_valid) begin
      if (use_rs1 && rs1_d != 0 && m_cnt[rs1_d] > 0) s = 1;
      if (use_rs2 && rs2_d != 0 && m_cnt[rs2_d] > 0) s = 1;
      if (issue_regwrite && issue_rd != 0 && m_cnt[issue_rd] == 3) s = 1;
    end
    return s;
  endfunction

  function automatic void model_update(input bit s);
    for (int r = 1; r < 32; r++) begin
      int n = m_cnt[r];
      if (issue_valid && issue_regwrite && !s && issue_rd == r) n = n + 1;
      if (retire_valid && retire_rd == r) n = n - 1;
      if (kill_valid && kill_rd == r) n = n - 1;
      if (n < 0) begin
        n = 0;
        m_err = 1;
      end
      m_cnt[r] = n;
    end
    if (s && m_stalls < 65535) m_stalls++;
  endfunction

  function automatic logic [31:0] model_pend();
    logic [31:0] p = '0;
    for (int r = 1; r < 32; r++) p[r] = (m_cnt[r] > 0);
    return p;
  endfunction

  task automatic idle_inputs();
    issue_valid = 0; issue_regwrite = 0; issue_rd = 0; rs1_d = 0; rs2_d = 0;
    use_rs1 = 0; use_rs2 = 0; retire_valid = 0; retire_rd = 0; kill_valid = 0; kill_rd = 0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 0;
    idle_inputs();
    for (int r = 0; r < 32; r++) m_cnt[r] = 0;
    m_err = 0;
    m_stalls = 0;
    #1;
    check("reset_stall", 32'(stall_d), 0);
    check("reset_pending", pending_vec, 0);
    check("reset_stall_count", 32'(stall_count), 0);
    check("reset_err", 32'(err_underflow), 0);
    @(negedge clk);
    rst = 1;
  endtask

  // Drive on the falling edge, check stall before the rising edge and the
  // registered outputs just after it.
  task automatic step(input vec_t v, input bit use_tbl);
    bit s;
    @(negedge clk);
    issue_valid = v.iv; issue_regwrite = v.rw; issue_rd = v.rd;
    rs1_d = v.rs1; rs2_d = v.rs2; use_rs1 = v.u1; use_rs2 = v.u2;
    retire_valid = v.rv; retire_rd = v.rrd; kill_valid = v.kv; kill_rd = v.krd;
    #1;
    s = model_stall();
    check("stall_model", 32'(stall_d), 32'(s));
    if (use_tbl) check("stall_table", 32'(stall_d), 32'(v.es));
    model_update(s);
    @(posedge clk);
    #1;
    check("pending_model", pending_vec, model_pend());
    check("stall_count_model", 32'(stall_count), 32'(m_stalls));
    check("err_model", 32'(err_underflow), 32'(m_err));
    if (use_tbl) begin
      check("pending_table", pending_vec, v.ep);
      check("err_table", 32'(err_underflow), 32'(v.ee));
    end
  endtask

  localparam logic [31:0] P3 = 32'h0000_0008;
  localparam logic [31:0] P5 = 32'h0000_0020;
  localparam logic [31:0] P7 = 32'h0000_0080;
  localparam logic [31:0] P8 = 32'h0000_0100;
  localparam logic [31:0] P9 = 32'h0000_0200;

  initial begin
    vec_t tbl[$];
    vec_t v;

    rst = 0;
    idle_inputs();

    //          iv rw rd rs1 rs2 u1 u2 rv rrd kv krd es ep  ee
    tbl.push_back(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, P5, 0)); // issue r5
    tbl.push_back(mk(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, P5, 0)); // read r5 -> stall
    tbl.push_back(mk(1, 0, 0, 5, 0, 1, 0, 1, 5, 0, 0, 1, 0, 0));  // retire r5, still stall
    tbl.push_back(mk(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0));  // released
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, P3, 0)); // r3 -> 1
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, P3, 0)); // r3 -> 2
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, P3, 0)); // r3 -> 3
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, P3, 0)); // full guard
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 1, 3, 0, 0, 1, P3, 0)); // stall + retire -> 2
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0, P3, 0)); // accepted -> 3
    tbl.push_back(mk(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 1, P3, 0)); // full again
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, P3, 0)); // -> 2
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, P3, 0)); // -> 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 3, 0, 0, 0, 0, 0));  // -> 0
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, P7, 0)); // r7 -> 1
    tbl.push_back(mk(1, 0, 0, 0, 7, 0, 1, 0, 0, 0, 0, 1, P7, 0)); // rs2 hazard
    tbl.push_back(mk(1, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, P7, 0)); // rs1 unused
    tbl.push_back(mk(1, 1, 7, 0, 0, 0, 0, 1, 7, 0, 0, 0, P7, 0)); // issue+retire r7
    tbl.push_back(mk(1, 1, 8, 0, 0, 0, 0, 1, 7, 0, 0, 0, P8, 0)); // issue r8, retire r7
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 8, 0, 0, 0, 0, 0));  // retire r8
    tbl.push_back(mk(1, 1, 0, 0, 0, 1, 1, 1, 0, 1, 0, 0, 0, 0));  // R0 traffic ignored
    tbl.push_back(mk(1, 1, 9, 0, 0, 0, 0, 0, 0, 0, 0, 0, P9, 0)); // r9 -> 1
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 1, 9, 1, 9, 0, 0, 1));  // double decrement
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1));  // error sticky

    do_reset();
    for (int i = 0; i < tbl.size(); i++) step(tbl[i], 1);
    check("table_stall_count", 32'(stall_count), 6);

    // Randomized traffic on a small register window to force hazards.
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      int r;
      v = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      v.iv  = ($urandom_range(3) != 0);
      v.rw  = $urandom_range(1);
      v.rd  = 5'($urandom_range(7));
      v.rs1 = 5'($urandom_range(7));
      v.rs2 = 5'($urandom_range(7));
      v.u1  = $urandom_range(1);
      v.u2  = $urandom_range(1);
      r = $urandom_range(7);
      v.rrd = 5'(r);
      v.rv  = (m_cnt[r] > 0) ? ($urandom_range(1) == 1) : ($urandom_range(39) == 0);
      r = $urandom_range(7);
      v.krd = 5'(r);
      v.kv  = (m_cnt[r] > 0) ? ($urandom_range(5) == 0) : ($urandom_range(79) == 0);
      step(v, 0);
    end

    // Long dependent stall: counter saturates, then async reset mid-stall.
    do_reset();
    step(mk(0, 0, 0, 0, 0, 0, 0, 1, 4, 0, 0, 0, 0, 1), 1);          // underflow on idle r4
    step(mk(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, P5, 1), 1);
    for (int i = 0; i < 70000; i++) step(mk(1, 0, 0, 5, 0, 1, 0, 0, 0, 0, 0, 1, P5, 1), 0);
    check("stall_count_saturated", 32'(stall_count), 32'hFFFF);
    check("stall_held", 32'(stall_d), 1);
    #2;
    rst = 0;
    #1;
    check("async_reset_stall", 32'(stall_d), 0);
    check("async_reset_pending", pending_vec, 0);
    check("async_reset_stall_count", 32'(stall_count), 0);
    check("async_reset_err", 32'(err_underflow), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_scoreboard.md
Name: reg_scoreboard

Overview:
- Tracks in-flight register writes between decode issue and writeback retire for the 5-stage pipeline.
- Decides when decode must stall because a source operand, or a destination whose counter is full, is still pending.
- Sits beside the decode stage. It consumes the decode-stage source and destination fields and the writeback write enable and destination. It drives the decode stall / execute-bubble signal.
- Provides a saturating stall-cycle counter and a sticky underflow error for debug.

Parameters:
- NREG, 32, number of architectural registers; R0 is hardwired zero and never pending.
- AW, 5, register address width.
- CW, 2, per-register pending counter width; at most 2^CW-1 in-flight writes per register.
- SCW, 16, stall-cycle counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- issue_valid  in  1  decode holds a valid instruction this cycle.
- issue_regwrite  in  1  that instruction writes a register (RegWriteD).
- issue_rd  in  AW  destination register of the decode instruction.
- rs1_d  in  AW  source register 1 of the decode instruction.
- rs2_d  in  AW  source register 2 of the decode instruction.
- use_rs1  in  1  instruction reads rs1_d.
- use_rs2  in  1  instruction reads rs2_d.
- retire_valid  in  1  writeback writes the register file this cycle (RegWriteW).
- retire_rd  in  AW  writeback destination (RDW).
- kill_valid  in  1  execute-stage instruction squashed by a taken branch and it had RegWrite set.
- kill_rd  in  AW  destination of the squashed instruction.
- stall_d  out  1  combinational; hold PC/fetch/decode and insert a bubble into execute.
- pending_vec  out  NREG  registered; bit i = 1 when count[i] != 0.
- stall_count  out  SCW  registered saturating count of stalled cycles.
- err_underflow  out  1  registered, sticky; set when a retire or kill hits a register with count 0.

Behaviour:
- State:
  - count[i] (CW bits) for i = 1..NREG-1; count[0] is constant 0.
  - stall_count.
  - err_underflow.
- Reset (rst = 0, async): all counts = 0, pending_vec = 0, stall_count = 0, err_underflow = 0. stall_d therefore reads 0 during reset.
- Stall is asserted, combinationally from the current counts, when any of the following holds. Register 0 never causes a stall.
  - issue_valid & use_rs1 & rs1_d != 0 & count[rs1_d] != 0.
  - issue_valid & use_rs2 & rs2_d != 0 & count[rs2_d] != 0.
  - issue_valid & issue_regwrite & issue_rd != 0 & count[issue_rd] == 2^CW-1 (saturation guard).
- Same-cycle retire does not clear a stall: the register file has no write-through bypass, so the stall releases the cycle after the count reaches 0.
- Accepted issue: inc = issue_valid & issue_regwrite & issue_rd != 0 & !stall_d.
- Per-register update each rising edge, for register r:
  - +1 if inc targets r.
  - −1 if retire_valid targets r (r != 0).
  - −1 if kill_valid targets r (r != 0).
  - Net delta is applied in one step and may be −2..+1. Issue plus retire on the same register → unchanged.
- Underflow: if the decrements requested for r exceed count[r] + increment, count[r] clamps to 0 and err_underflow sets. err_underflow clears only on reset.
- Overflow cannot occur, because the saturation guard stalls first.
- stall_count increments on each edge where stall_d = 1 and saturates at 2^SCW-1 (no wrap).
- pending_vec updates on the same edge as the counts (1-cycle latency from issue/retire).
- Zero-register traffic (issue, retire or kill targeting R0) is ignored with no error.
- Reset mid-operation discards all pending state immediately. The pipeline is reset together with this block.

Test Plan:
- Reset, then issue rd=5 (regwrite=1); next cycle decode rs1=5, use_rs1=1 → stall_d = 1, pending_vec[5] = 1. Retire rd=5 at cycle t → stall_d still 1 at t, 0 at t+1, pending_vec[5] = 0, stall_count equals the number of stalled cycles.
- Issue rd=3 three times back-to-back (CW=2) with no retire → count[3] = 3. A fourth issue to rd=3 → stall_d = 1 and no increment. One retire → 4th issue accepted next cycle, count[3] = 3.
- Issue rd=7 and retire rd=7 in the same cycle with count[7] = 1 → count[7] stays 1, pending_vec[7] = 1. Separately, issue rd=8 and retire rd=7 in one cycle → count[7] = 0, count[8] = 1.
- count[9] = 1, then kill_valid rd=9 and retire_valid rd=9 in one cycle → count[9] = 0 and err_underflow = 1, staying 1 until rst.
- Issue rd=0, read rs1=0 / rs2=0, retire rd=0 → stall_d = 0 always, pending_vec = 0, err_underflow = 0.
- Hold a dependent stall for 70000 cycles (SCW=16) → stall_count = 65535. Assert rst low mid-stall → all outputs 0 asynchronously, before the next clock edge.
